median_rank_filter: RTL
=======================

Name: median_rank_filter

Overview:
Parametrised successor to the serial 3x3 median block: it accepts a window of N samples of WIDTH bits, one per clock while DSI is high. It keeps them in an ascending insertion-sorted register array and returns the sample of a run-time-selected rank (min, median, max or any index). It sits in the image-filter pipeline between the pixel window streamer and the output writer, and keeps the DI/DSI -> DO/DSO streaming protocol.

Parameters:
WIDTH, 8, bit width of one sample (DI/DO).
N, 9, samples per window; odd, 3..25.
RW, $clog2(N), width of RANK port (derived, not overridden).

Ports:
CLK  input  1  clock, all logic on rising edge.
RST  input  1  synchronous active-high reset.
DI  input  WIDTH  sample, valid when DSI=1.
DSI  input  1  sample strobe; one sample accepted per cycle DSI=1.
RANK  input  RW  selected rank, 0=min, (N-1)/2=median, N-1=max; sampled on the edge accepting the Nth sample.
DO  output  WIDTH  selected-rank result; held until the next result.
DSO  output  1  one-cycle pulse: DO updated this cycle.
ERR  output  1  present only with MEDIAN_GAP_ABORT_EN; see Optional Feature.

Behaviour:
- Interface: clock CLK; reset RST is synchronous, active-high.
- Reset, RST=1 at the edge: DO=0, DSO=0, ERR=0, sample count=0, all slot valid bits cleared. Reset overrides DSI in the same cycle and discards any partial window.
- Storage: N slots s[0..N-1] with valid bits v[], kept ascending. Invalid slots compare as +infinity.
- Counter cnt (0..N-1) counts accepted samples in the current window.
- Insertion on each edge with DSI=1, given x=DI:
  - s[i] keeps its value if v[i] and s[i]<=x.
  - Otherwise s[i] takes x if i==0 or (v[i-1] and s[i-1]<=x).
  - Otherwise s[i] takes s[i-1].
  - Valid bits shift the same way. Equal values insert after existing equals.
- First sample (cnt==0): the array is treated as all-invalid before insertion, so no clear cycle is needed.
- Nth sample (cnt==N-1), on the same edge:
  - DO <= next-state s[min(RANK,N-1)], computed from the array including x.
  - DSO <= 1; cnt <= 0.
  - Result appears one cycle after the last sample.
- Other cycles: DSO <= 0.
- Back-to-back windows: a DSI=1 sample on the cycle after the Nth sample starts a new window. Full throughput is N samples per N cycles with no bubble.
- RANK >= N (non-power-of-two N) saturates to N-1.
- DSI gap (default build): DSI=0 mid-window pauses; cnt and array hold, and accumulation resumes on the next DSI=1.
- DO is never changed except on a DSO cycle or by reset.

Optional Feature:
Macro MEDIAN_GAP_ABORT_EN.
- Defined:
  - A DSI=0 cycle while 0<cnt<N aborts the window: cnt<=0, valid bits cleared, no DSO.
  - ERR pulses high for one cycle on the edge after the gap.
  - DO keeps its previous value.
- Undefined: no ERR port; gaps pause as above.

Decomposition:
- Package median_pkg:
  - Sample typedef template (logic [WIDTH-1:0] via parameterised struct or localparam width).
  - Rank constants RANK_MIN=0, RANK_MED(N)=(N-1)/2 function, RANK_MAX(N)=N-1.
  - Window-size legality check function used in an elaboration-time assertion.
- Sub-module median_slot: one compare-and-shift cell with inputs (x, own value/valid, lower neighbour value/valid, first) and outputs (next value, next valid). It is instantiated N times by generate.

Test Plan:
- N=9, WIDTH=8, RANK=4: DI 9,1,8,2,7,3,6,4,5 on 9 consecutive cycles -> DSO high exactly one cycle after 5 is accepted, DO=5.
- Same window with RANK=0 then RANK=8 -> DO=1 then DO=9; RANK=15 -> DO=9 (saturated).
- Duplicates: all nine DI=200 -> DO=200. Window 0,255,0,255,0,255,0,255,0 at RANK=4 -> DO=0.
- Back-to-back: windows {10..18} then {90..98} with DSI held high 18 cycles -> two DSO pulses 9 cycles apart, DO=14 then 94.
- Gap: 4 samples, DSI=0 for 3 cycles, 5 more samples:
  - Default build -> DO equals the median of all 9 samples.
  - MEDIAN_GAP_ABORT_EN -> ERR pulse, no DSO, DO unchanged.
- Reset mid-window: RST=1 after 5 samples, then a full window of 3,3,3,3,3,3,3,3,7 -> exactly one DSO, DO=3, and no contamination from pre-reset samples.

Source files
------------

// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared definitions for the rank filter:
//   - MEDIAN_WIDTH / median_sample_t : default sample width and sample type
//   - RANK_MIN, rank_med(), rank_max() : rank select helpers
//   - median_window_legal()          : legal window sizes (odd, 3..25)
// -----------------------------------------------------------------------------
package median_pkg;

    localparam int MEDIAN_WIDTH = 8;
    localparam int MEDIAN_N_MIN = 3;
    localparam int MEDIAN_N_MAX = 25;

    typedef logic [MEDIAN_WIDTH-1:0] median_sample_t;

    localparam int RANK_MIN = 0;

    function automatic int rank_med(input int n);
        return (n - 1) / 2;
    endfunction

    function automatic int rank_max(input int n);
        return n - 1;
    endfunction

    function automatic bit median_window_legal(input int n);
        return ((n % 2) == 1) && (n >= MEDIAN_N_MIN) && (n <= MEDIAN_N_MAX);
    endfunction

endpackage

// File: rtl/median_rank_filter_if.sv
// -----------------------------------------------------------------------------
// median_rank_filter_if
// Streaming bus between the window streamer (master) and the rank filter
// (slave).
//   DI   : sample, valid while DSI=1
//   DSI  : sample strobe
//   RANK : selected rank, taken with the last sample of a window
//   DO   : selected-rank result, held until the next result
//   DSO  : one-cycle pulse marking a new DO
//   ERR  : window-abort pulse, only when MEDIAN_GAP_ABORT_EN is defined
// -----------------------------------------------------------------------------
interface median_rank_filter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 9,
    localparam int RW   = $clog2(N)
);
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [RW-1:0]    RANK;
    logic [WIDTH-1:0] DO;
    logic             DSO;
`ifdef MEDIAN_GAP_ABORT_EN
    logic             ERR;

    modport master (output DI, DSI, RANK, input DO, DSO, ERR);
    modport slave  (input DI, DSI, RANK, output DO, DSO, ERR);
`else
    modport master (output DI, DSI, RANK, input DO, DSO);
    modport slave  (input DI, DSI, RANK, output DO, DSO);
`endif
endinterface

// File: rtl/median_rank_filter_chk.sv
// -----------------------------------------------------------------------------
// median_rank_filter_chk
// Checks for the rank filter: window size legality at elaboration and
// the single-cycle nature of the DSO pulse during operation.
//   CLK, RST : filter clock and synchronous reset
//   dso      : the filter's DSO output
// -----------------------------------------------------------------------------
module median_rank_filter_chk
    import median_pkg::*;
#(
    parameter int N = 9
) (
    input logic CLK,
    input logic RST,
    input logic dso
);

    if (!median_window_legal(N)) begin : g_bad_n
        $error("median_rank_filter: N=%0d must be odd and within 3..25", N);
    end

    logic dso_q_r;

    // Remember last cycle's DSO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dso_q_r <= 1'b0;
        end else begin
            dso_q_r <= dso;
        end
    end

    // With N >= 3, two results can never be one cycle apart.
    always_ff @(posedge CLK) begin
        if (!RST && dso_q_r) begin
            assert (!dso) else $error("median_rank_filter: DSO high two cycles in a row");
        end
    end

endmodule

// File: rtl/median_slot.sv
// -----------------------------------------------------------------------------
// median_slot
// One compare-and-shift cell of the ascending insertion array.
//   x        : incoming sample
//   own_*    : this slot's current value/valid
//   low_*    : lower neighbour's current value/valid
//   first    : this is slot 0 (no lower neighbour)
//   nxt_*    : value/valid this slot takes when a sample is inserted
// An invalid slot behaves as +infinity; equal values stay ahead of x, so
// a new duplicate lands after the existing ones.
// -----------------------------------------------------------------------------
module median_slot
    import median_pkg::*;
#(
    parameter int WIDTH = MEDIAN_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] own_val,
    input  logic             own_vld,
    input  logic [WIDTH-1:0] low_val,
    input  logic             low_vld,
    input  logic             first,
    output logic [WIDTH-1:0] nxt_val,
    output logic             nxt_vld
);

    logic keep_s;
    logic take_x_s;

    // Decide whether to keep, take the new sample, or shift up the neighbour.
    always_comb begin
        keep_s   = own_vld && (own_val <= x);
        take_x_s = first || (low_vld && (low_val <= x));
        nxt_val  = own_val;
        nxt_vld  = own_vld;
        if (keep_s) begin
            nxt_val = own_val;
            nxt_vld = 1'b1;
        end else if (take_x_s) begin
            nxt_val = x;
            nxt_vld = 1'b1;
        end else begin
            nxt_val = low_val;
            nxt_vld = low_vld;
        end
    end

endmodule

// File: rtl/median_rank_filter.sv
// -----------------------------------------------------------------------------
// median_rank_filter
// Collects a window of N samples, one per DSI=1 cycle, into an ascending
// insertion-sorted array and outputs the sample of the chosen rank one
// cycle after the last sample of the window.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : median_rank_filter_if.slave (DI, DSI, RANK in; DO, DSO[, ERR] out)
// Build option MEDIAN_GAP_ABORT_EN: a DSI=0 cycle inside a window aborts
// it and pulses ERR; without it a gap only pauses accumulation.
// -----------------------------------------------------------------------------
module median_rank_filter
    import median_pkg::*;
#(
    parameter int WIDTH = MEDIAN_WIDTH,
    parameter int N     = 9,
    localparam int RW   = $clog2(N)
) (
    input  logic               CLK,
    input  logic               RST,
    median_rank_filter_if.slave bus
);

    localparam logic [RW-1:0] LAST_IDX = RW'(rank_max(N));

    logic [WIDTH-1:0] val_r [N];
    logic [N-1:0]     vld_r;
    logic [RW-1:0]    cnt_r;
    logic [WIDTH-1:0] do_r;
    logic             dso_r;
`ifdef MEDIAN_GAP_ABORT_EN
    logic             err_r;
`endif

    logic [WIDTH-1:0] nxt_val_s [N];
    logic [N-1:0]     nxt_vld_s;
    logic [N-1:0]     eff_vld_s;
    logic [RW-1:0]    rank_sat_s;
    logic             last_s;

    // A new window sees an empty array, so no clear cycle is needed between windows.
    always_comb begin
        if (cnt_r == {RW{1'b0}}) begin
            eff_vld_s = {N{1'b0}};
        end else begin
            eff_vld_s = vld_r;
        end
    end

    // Saturate out-of-range ranks to the maximum and flag the closing sample.
    always_comb begin
        if (bus.RANK > LAST_IDX) begin
            rank_sat_s = LAST_IDX;
        end else begin
            rank_sat_s = bus.RANK;
        end
        last_s = bus.DSI && (cnt_r == LAST_IDX);
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        if (i == 0) begin : g_first
            median_slot #(.WIDTH(WIDTH)) u_slot (
                .x       (bus.DI),
                .own_val (val_r[0]),
                .own_vld (eff_vld_s[0]),
                .low_val (bus.DI),
                .low_vld (1'b0),
                .first   (1'b1),
                .nxt_val (nxt_val_s[0]),
                .nxt_vld (nxt_vld_s[0])
            );
        end else begin : g_rest
            median_slot #(.WIDTH(WIDTH)) u_slot (
                .x       (bus.DI),
                .own_val (val_r[i]),
                .own_vld (eff_vld_s[i]),
                .low_val (val_r[i-1]),
                .low_vld (eff_vld_s[i-1]),
                .first   (1'b0),
                .nxt_val (nxt_val_s[i]),
                .nxt_vld (nxt_vld_s[i])
            );
        end
    end

    // Sample array: updated on every accepted sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                val_r[i] <= {WIDTH{1'b0}};
            end
        end else if (bus.DSI) begin
            for (int i = 0; i < N; i++) begin
                val_r[i] <= nxt_val_s[i];
            end
        end
    end

    // Window control: valid bits, sample count, result and strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_r <= {N{1'b0}};
            cnt_r <= {RW{1'b0}};
            do_r  <= {WIDTH{1'b0}};
            dso_r <= 1'b0;
`ifdef MEDIAN_GAP_ABORT_EN
            err_r <= 1'b0;
`endif
        end else begin
            dso_r <= 1'b0;
`ifdef MEDIAN_GAP_ABORT_EN
            err_r <= 1'b0;
`endif
            if (bus.DSI) begin
                vld_r <= nxt_vld_s;
                if (last_s) begin
                    // Result comes from the array including the closing sample.
                    do_r  <= nxt_val_s[rank_sat_s];
                    dso_r <= 1'b1;
                    cnt_r <= {RW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + RW'(1);
                end
            end
`ifdef MEDIAN_GAP_ABORT_EN
            else if (cnt_r != {RW{1'b0}}) begin
                vld_r <= {N{1'b0}};
                cnt_r <= {RW{1'b0}};
                err_r <= 1'b1;
            end
`endif
        end
    end

    assign bus.DO  = do_r;
    assign bus.DSO = dso_r;
`ifdef MEDIAN_GAP_ABORT_EN
    assign bus.ERR = err_r;
`endif

    median_rank_filter_chk #(.N(N)) u_chk (
        .CLK (CLK),
        .RST (RST),
        .dso (dso_r)
    );

endmodule
